// File: rtl/cam_sccb_master.sv
// Single-transaction SCCB/I2C write master: START, four bytes (address, register hi/lo, data), STOP.
// SCL runs at clk400/4; both pins are open drain (drive 0 or release).
module cam_sccb_master (
   input  logic        clk400,
   input  logic        reset,
   input  logic        send_data,
   input  logic [7:0]  slave_addr,
   input  logic [15:0] register_in,
   input  logic [7:0]  datain,
   input  logic        ackn,
   output logic        ready,
   output logic        nack,
   inout  wire         scl,
   inout  wire         sda
);

   // S_ARM is the one quiet cycle between acceptance and the START condition.
   typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_BIT, S_STOP} state_t;

   state_t      state_q;
   logic [1:0]  phase_q;
   logic [3:0]  bit_q;
   logic [1:0]  byte_q;
   logic [31:0] shift_q;
   logic        scl_low_q;
   logic        sda_low_q;
   logic        ready_q;
   logic        nack_q;
   logic        ack_fail_q;
   logic        unused_addr_msb;

   assign unused_addr_msb = slave_addr[7];

   assign scl   = scl_low_q ? 1'b0 : 1'bz;
   assign sda   = sda_low_q ? 1'b0 : 1'bz;
   assign ready = ready_q;
   assign nack  = nack_q;

   // Pin registers hold the level for the cycle that starts at this edge.
   always_ff @(posedge clk400) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= 2'd0;
         bit_q      <= 4'd0;
         byte_q     <= 2'd0;
         shift_q    <= 32'd0;
         scl_low_q  <= 1'b0;
         sda_low_q  <= 1'b0;
         ready_q    <= 1'b1;
         nack_q     <= 1'b0;
         ack_fail_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (send_data) begin
                  shift_q    <= {slave_addr[6:0], 1'b0, register_in, datain};
                  nack_q     <= 1'b0;
                  ack_fail_q <= 1'b0;
                  ready_q    <= 1'b0;
                  state_q    <= S_ARM;
               end
            end

            S_ARM: begin
               state_q   <= S_START;
               phase_q   <= 2'd0;
               sda_low_q <= 1'b1;
            end

            S_START: begin
               if (phase_q == 2'd0) begin
                  phase_q   <= 2'd1;
                  scl_low_q <= 1'b1;
               end else begin
                  state_q   <= S_BIT;
                  phase_q   <= 2'd0;
                  bit_q     <= 4'd0;
                  byte_q    <= 2'd0;
                  sda_low_q <= ~shift_q[31];
               end
            end

            S_BIT: begin
               case (phase_q)
                  2'd0: begin
                     scl_low_q <= 1'b0;
                     phase_q   <= 2'd1;
                  end
                  2'd1: begin
                     phase_q <= 2'd2;
                  end
                  2'd2: begin
                     scl_low_q  <= 1'b1;
                     phase_q    <= 2'd3;
                     ack_fail_q <= (bit_q == 4'd8) && (sda == 1'b1);
                     if ((bit_q == 4'd8) && (sda == 1'b1)) begin
                        nack_q <= 1'b1;
                     end
                  end
                  default: begin
                     phase_q <= 2'd0;
                     if (bit_q != 4'd8) begin
                        shift_q   <= {shift_q[30:0], 1'b0};
                        bit_q     <= bit_q + 4'd1;
                        sda_low_q <= (bit_q == 4'd7) ? 1'b0 : ~shift_q[30];
                     end else if ((ack_fail_q && !ackn) || (byte_q == 2'd3)) begin
                        state_q   <= S_STOP;
                        sda_low_q <= 1'b1;
                        bit_q     <= 4'd0;
                        byte_q    <= 2'd0;
                     end else begin
                        bit_q     <= 4'd0;
                        byte_q    <= byte_q + 2'd1;
                        sda_low_q <= ~shift_q[31];
                     end
                  end
               endcase
            end

            S_STOP: begin
               if (phase_q == 2'd0) begin
                  phase_q   <= 2'd1;
                  scl_low_q <= 1'b0;
               end else if (phase_q == 2'd1) begin
                  phase_q   <= 2'd2;
                  sda_low_q <= 1'b0;
               end else begin
                  phase_q <= 2'd0;
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end

            default: begin
               state_q   <= S_IDLE;
               scl_low_q <= 1'b0;
               sda_low_q <= 1'b0;
               ready_q   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_sccb_master.sv
// Directed bench for cam_sccb_master: bus monitor/ACK slave, protocol watch and per-scenario checks.
`timescale 1ns/1ns
module tb_cam_sccb_master;

   logic        clk400 = 1'b0;
   logic        reset = 1'b1;
   logic        send_data = 1'b0;
   logic [7:0]  slave_addr = 8'h00;
   logic [15:0] register_in = 16'h0000;
   logic [7:0]  datain = 8'h00;
   logic        ackn = 1'b0;
   logic        ready;
   logic        nack;
   wire         scl;
   wire         sda;

   pullup (scl);
   pullup (sda);

   logic slave_drv = 1'b0;
   assign sda = slave_drv ? 1'b0 : 1'bz;

   cam_sccb_master dut (
      .clk400      (clk400),
      .reset       (reset),
      .send_data   (send_data),
      .slave_addr  (slave_addr),
      .register_in (register_in),
      .datain      (datain),
      .ackn        (ackn),
      .ready       (ready),
      .nack        (nack),
      .scl         (scl),
      .sda         (sda)
   );

   always #1250 clk400 = ~clk400;

   int n_chk = 0;
   int n_pass = 0;

   // Bus monitor and slave model
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];
   int  start_cnt = 0;
   int  stop_cnt = 0;
   int  stop_bytes = 0;
   int  proto_err = 0;
   int  nack_sel = -1;
   bit  mon_en = 1'b0;

   initial begin
      logic       prev_scl, prev_sda, cs, cd, in_frame;
      logic [7:0] sh;
      int         bit_cnt, byte_idx;
      prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; sh = 8'h00;
      bit_cnt = 0; byte_idx = 0;
      forever begin
         @(negedge clk400);
         cs = scl;
         cd = sda;
         if (!mon_en) begin
            in_frame = 1'b0; bit_cnt = 0; byte_idx = 0; slave_drv = 1'b0;
         end else begin
            if (prev_scl === 1'b1 && cs === 1'b1 && cd !== prev_sda) begin
               if (cd === 1'b0) begin
                  if (in_frame) proto_err++;
                  start_cnt++; in_frame = 1'b1; bit_cnt = 0; byte_idx = 0;
               end else begin
                  // a STOP follows the single SCL rise after the last ACK slot
                  if (!in_frame || bit_cnt != 1 || sh[0] !== 1'b0) proto_err++;
                  stop_cnt++; stop_bytes = byte_idx; in_frame = 1'b0; bit_cnt = 0;
               end
            end else if (prev_scl === 1'b0 && cs === 1'b1 && in_frame) begin
               if (bit_cnt < 8) begin
                  sh = {sh[6:0], cd};
                  bit_cnt++;
               end else begin
                  obs_q.push_back(sh);
                  bit_cnt = 0;
                  byte_idx++;
               end
            end
            if (cs === 1'b0) slave_drv = in_frame && (bit_cnt == 8) && (byte_idx != nack_sel);
         end
         prev_scl = cs;
         prev_sda = cd;
      end
   end

   // Driver tasks
   task automatic issue(input logic [7:0] a, input logic [15:0] r, input logic [7:0] d, input logic ak);
      @(negedge clk400);
      slave_addr = a; register_in = r; datain = d; ackn = ak; send_data = 1'b1;
      @(posedge clk400);
      #1 send_data = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk400);
         cyc++;
         #1;
      end while (!ready && cyc < 400);
   endtask

   // Scenarios
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk400);
      #1;
      n_chk++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
      n_chk++; if (nack !== 1'b0) $display("FAIL reset_nack: got %b want 0", nack); else n_pass++;
      n_chk++; if (scl !== 1'b1) $display("FAIL reset_scl: got %b want 1 (released)", scl); else n_pass++;
      n_chk++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1 (released)", sda); else n_pass++;
      @(negedge clk400);
      reset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      int cyc, base, st0, sp0;
      base = obs_q.size(); st0 = start_cnt; sp0 = stop_cnt;
      exp_q = {8'h20, 8'h01, 8'h00, 8'h01};
      nack_sel = -1;
      issue(8'd16, 16'h0100, 8'h01, 1'b0);
      n_chk++; if (ready !== 1'b0) $display("FAIL basic_ready_drop: got %b want 0", ready); else n_pass++;
      wait_ready(cyc);
      n_chk++; if (cyc !== 150) $display("FAIL basic_cycles: got %0d want 150", cyc); else n_pass++;
      n_chk++; if (nack !== 1'b0) $display("FAIL basic_nack: got %b want 0", nack); else n_pass++;
      n_chk++; if (start_cnt - st0 !== 1) $display("FAIL basic_starts: got %0d want 1", start_cnt - st0); else n_pass++;
      n_chk++; if (stop_cnt - sp0 !== 1) $display("FAIL basic_stops: got %0d want 1", stop_cnt - sp0); else n_pass++;
      n_chk++; if (stop_bytes !== 4) $display("FAIL basic_stop_after: got %0d want 4", stop_bytes); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL basic_nbytes: got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_nack(input logic ak, input int exp_cyc);
      int cyc, base, sp0;
      base = obs_q.size(); sp0 = stop_cnt;
      if (ak) exp_q = {8'h84, 8'hA5, 8'h5A, 8'h3C};
      else    exp_q = {8'h84, 8'hA5};
      nack_sel = 1;
      issue(8'h42, 16'hA55A, 8'h3C, ak);
      wait_ready(cyc);
      nack_sel = -1;
      n_chk++; if (cyc !== exp_cyc) $display("FAIL nack%0d_cycles: got %0d want %0d", ak, cyc, exp_cyc); else n_pass++;
      n_chk++; if (nack !== 1'b1) $display("FAIL nack%0d_flag: got %b want 1", ak, nack); else n_pass++;
      n_chk++; if (stop_cnt - sp0 !== 1) $display("FAIL nack%0d_stops: got %0d want 1", ak, stop_cnt - sp0); else n_pass++;
      n_chk++; if (stop_bytes !== exp_q.size()) $display("FAIL nack%0d_stop_after: got %0d want %0d", ak, stop_bytes, exp_q.size()); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL nack%0d_nbytes: got %0d want %0d", ak, obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL nack%0d_byte%0d: got %h want %h", ak, i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_held_high();
      int cyc, base, sp0;
      base = obs_q.size(); sp0 = stop_cnt;
      exp_q = {8'h42, 8'hBE, 8'hEF, 8'h77, 8'h42, 8'hBE, 8'hEF, 8'h77};
      @(negedge clk400);
      slave_addr = 8'h21; register_in = 16'hBEEF; datain = 8'h77; ackn = 1'b0; send_data = 1'b1;
      @(posedge clk400);
      #1;
      n_chk++; if (nack !== 1'b0) $display("FAIL held_nack_clear: got %b want 0", nack); else n_pass++;
      wait_ready(cyc);
      n_chk++; if (cyc !== 150) $display("FAIL held_cycles1: got %0d want 150", cyc); else n_pass++;
      @(posedge clk400);
      #1;
      n_chk++; if (ready !== 1'b0) $display("FAIL held_reaccept: got %b want 0", ready); else n_pass++;
      send_data = 1'b0;
      wait_ready(cyc);
      n_chk++; if (cyc !== 150) $display("FAIL held_cycles2: got %0d want 150", cyc); else n_pass++;
      n_chk++; if (stop_cnt - sp0 !== 2) $display("FAIL held_stops: got %0d want 2", stop_cnt - sp0); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL held_nbytes: got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL held_byte%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_busy_ignore();
      int cyc, base, sp0;
      base = obs_q.size(); sp0 = stop_cnt;
      exp_q = {8'h20, 8'h12, 8'h34, 8'h56};
      issue(8'h10, 16'h1234, 8'h56, 1'b0);
      repeat (39) @(posedge clk400);
      @(negedge clk400);
      slave_addr = 8'h7F; register_in = 16'hFFFF; datain = 8'hFF; send_data = 1'b1;
      @(posedge clk400);
      #1 send_data = 1'b0;
      n_chk++; if (ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", ready); else n_pass++;
      wait_ready(cyc);
      n_chk++; if (cyc !== 110) $display("FAIL busy_cycles: got %0d want 110", cyc); else n_pass++;
      n_chk++; if (stop_cnt - sp0 !== 1) $display("FAIL busy_stops: got %0d want 1", stop_cnt - sp0); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL busy_nbytes: got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL busy_byte%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int cyc, base, st0, sp0;
      logic [7:0]  a, d;
      logic [15:0] r;
      base = obs_q.size(); st0 = start_cnt; sp0 = stop_cnt;
      exp_q.delete();
      for (int i = 0; i < 59; i++) begin
         a = 8'(i) | ((i % 2 == 1) ? 8'h80 : 8'h00);
         r = {8'(i), ~8'(i)};
         d = 8'(i * 3);
         exp_q.push_back({a[6:0], 1'b0});
         exp_q.push_back(r[15:8]);
         exp_q.push_back(r[7:0]);
         exp_q.push_back(d);
         issue(a, r, d, 1'b0);
         wait_ready(cyc);
         n_chk++; if (cyc !== 150) $display("FAIL b2b_cycles%0d: got %0d want 150", i, cyc); else n_pass++;
      end
      n_chk++; if (start_cnt - st0 !== 59) $display("FAIL b2b_starts: got %0d want 59", start_cnt - st0); else n_pass++;
      n_chk++; if (stop_cnt - sp0 !== 59) $display("FAIL b2b_stops: got %0d want 59", stop_cnt - sp0); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL b2b_nbytes: got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int cyc, base, st0;
      issue(8'h10, 16'h0100, 8'h01, 1'b0);
      repeat (59) @(posedge clk400);
      #1;
      mon_en = 1'b0;
      reset = 1'b1;
      @(posedge clk400);
      #1;
      n_chk++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready); else n_pass++;
      n_chk++; if (scl !== 1'b1) $display("FAIL rstmid_scl: got %b want 1 (released)", scl); else n_pass++;
      n_chk++; if (sda !== 1'b1) $display("FAIL rstmid_sda: got %b want 1 (released)", sda); else n_pass++;
      reset = 1'b0;
      @(negedge clk400);
      mon_en = 1'b1;
      base = obs_q.size(); st0 = start_cnt;
      exp_q = {8'h20, 8'h01, 8'h00, 8'h01};
      issue(8'd16, 16'h0100, 8'h01, 1'b0);
      wait_ready(cyc);
      n_chk++; if (cyc !== 150) $display("FAIL rstmid_cycles: got %0d want 150", cyc); else n_pass++;
      n_chk++; if (start_cnt - st0 !== 1) $display("FAIL rstmid_starts: got %0d want 1", start_cnt - st0); else n_pass++;
      n_chk++; if (stop_bytes !== 4) $display("FAIL rstmid_stop_after: got %0d want 4", stop_bytes); else n_pass++;
      n_chk++; if (obs_q.size() - base !== exp_q.size()) $display("FAIL rstmid_nbytes: got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         n_chk++; if (obs_q[base+i] !== exp_q[i]) $display("FAIL rstmid_byte%0d: got %h want %h", i, obs_q[base+i], exp_q[i]); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nack(1'b0, 78);
      test_nack(1'b1, 150);
      test_held_high();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      n_chk++; if (proto_err !== 0) $display("FAIL protocol: got %0d violations want 0", proto_err); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
